// File: rtl/zigzag_pingpong_buffer.sv
// rtl/zigzag_pingpong_buffer.sv - double-buffered 8x8 row-in, zigzag-out coefficient buffer
module zigzag_pingpong_buffer #(
    parameter int DATA_WIDTH = 10,
    parameter int OUT_LANES  = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            sync_clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [8*DATA_WIDTH-1:0]         in_row,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            out_first,
    output logic                            out_last
);

    localparam int BEATS  = 64 / OUT_LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Zigzag scan index -> row-major position inside the 8x8 block.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DATA_WIDTH-1:0] bank_mem [2][64];
    logic [1:0]            full;
    logic                  wr_bank;
    logic [2:0]            wr_row;
    logic                  rd_bank;
    logic [BEAT_W-1:0]     rd_beat;

    logic                  in_fire;
    logic                  out_fire;
    logic                  last_beat;
    logic [1:0]            full_set;
    logic [1:0]            full_clr;
    logic [5:0]            zz_idx;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (rd_beat == BEAT_W'(BEATS - 1));
    assign out_first = out_valid && (rd_beat == '0);
    assign out_last  = out_valid && last_beat;

    // Bank-full transitions: writer fills only empty banks, reader drains only full ones.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (in_fire && (wr_row == 3'd7)) begin
            full_set[wr_bank] = 1'b1;
        end
        if (out_fire && last_beat) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    // Pointer and flag state; sync_clear drops any handshake in its cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_beat <= '0;
        end else if (sync_clear) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_beat <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (in_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (out_fire) begin
                if (last_beat) begin
                    rd_beat <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_beat <= rd_beat + 1'b1;
                end
            end
        end
    end

    // Row storage; contents are deliberately not reset since they are unobservable until rewritten.
    always_ff @(posedge clock) begin
        if (in_fire && !sync_clear) begin
            for (int c = 0; c < 8; c++) begin
                bank_mem[wr_bank][{wr_row, 3'(c)}] <= in_row[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Beat assembly straight from registered state so output never depends on in_valid/out_ready.
    always_comb begin
        out_data = '0;
        zz_idx   = '0;
        if (out_valid) begin
            for (int k = 0; k < OUT_LANES; k++) begin
                zz_idx = 6'(int'(rd_beat) * OUT_LANES + k);
                out_data[k*DATA_WIDTH +: DATA_WIDTH] = bank_mem[rd_bank][ZZ[zz_idx]];
            end
        end
    end

endmodule

// File: tb/tb_zigzag_pingpong_buffer.sv
// tb/tb_zigzag_pingpong_buffer.sv - self-checking bench for zigzag_pingpong_buffer
module tb_zigzag_pingpong_buffer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        sync_clear;
    logic        in_valid, in_ready;
    logic [79:0] in_row;
    logic        out_valid, out_ready;
    logic [79:0] out_data;
    logic        out_first, out_last;

    logic        a_sync_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last;
    logic [79:0] a_in_row;
    logic [9:0]  a_out_data;

    logic         b_sync_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_first, b_out_last;
    logic [95:0]  b_in_row;
    logic [767:0] b_out_data;

    zigzag_pingpong_buffer #(.DATA_WIDTH(10), .OUT_LANES(8)) dut (
        .clock(clock), .reset_n(reset_n), .sync_clear(sync_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last));

    zigzag_pingpong_buffer #(.DATA_WIDTH(10), .OUT_LANES(1)) dut_l1 (
        .clock(clock), .reset_n(reset_n), .sync_clear(a_sync_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_first(a_out_first), .out_last(a_out_last));

    zigzag_pingpong_buffer #(.DATA_WIDTH(12), .OUT_LANES(64)) dut_l64 (
        .clock(clock), .reset_n(reset_n), .sync_clear(b_sync_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_first(b_out_first), .out_last(b_out_last));

    int zz [64] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    typedef struct {
        logic [79:0] data;
        logic        first;
        logic        last;
    } vec_t;
    vec_t vec [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [79:0] mk_row(input int base, input int r);
        logic [79:0] v;
        for (int c = 0; c < 8; c++) v[c*10 +: 10] = 10'(base + r*8 + c);
        return v;
    endfunction

    function automatic logic [79:0] exp_beat(input int base, input int b);
        logic [79:0] v;
        for (int k = 0; k < 8; k++) v[k*10 +: 10] = 10'(base + zz[b*8 + k]);
        return v;
    endfunction

    task automatic send_block(input int base);
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            in_row   = mk_row(base, r);
            chk("send_in_ready", in_ready, 1'b1);
            chk("send_no_early_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_table(input string tag);
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            chk({tag, "_valid"}, out_valid, 1'b1);
            chk({tag, "_data"},  out_data,  vec[b].data);
            chk({tag, "_first"}, out_first, vec[b].first);
            chk({tag, "_last"},  out_last,  vec[b].last);
            tick();
        end
        chk({tag, "_valid_falls"}, out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [767:0] b_exp;
        logic [95:0]  brow;
        logic [79:0]  prev_data;
        logic         prev_first, prev_last, stalled;
        logic [79:0]  exp_q [$];
        int acc, blk, rows_sent, obeat, cyc;

        for (int b = 0; b < 8; b++) begin
            vec[b].data  = exp_beat(0, b);
            vec[b].first = (b == 0);
            vec[b].last  = (b == 7);
        end
        vec[0].data = {10'd10, 10'd3, 10'd2, 10'd9, 10'd16, 10'd8, 10'd1, 10'd0};
        vec[7].data = {10'd63, 10'd62, 10'd55, 10'd47, 10'd54, 10'd61, 10'd60, 10'd53};

        reset_n = 1'b0;
        sync_clear = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
        a_sync_clear = 1'b0; a_in_valid = 1'b0; a_in_row = '0; a_out_ready = 1'b0;
        b_sync_clear = 1'b0; b_in_valid = 1'b0; b_in_row = '0; b_out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  80'd0);
        chk("rst_out_first", out_first, 1'b0);
        chk("rst_out_last",  out_last,  1'b0);
        reset_n = 1'b1;
        tick();

        // Parameter sweep: OUT_LANES=1 and OUT_LANES=64 with 12-bit negative values
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            a_in_row = mk_row(0, r);
            for (int c = 0; c < 8; c++) brow[c*12 +: 12] = 12'(4095 - (r*8 + c));
            b_in_row = brow;
            chk("l1_in_ready", a_in_ready, 1'b1);
            chk("l64_in_ready", b_in_ready, 1'b1);
            tick();
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        for (int k = 0; k < 64; k++) b_exp[k*12 +: 12] = 12'(4095 - zz[k]);
        chk("l64_valid", b_out_valid, 1'b1);
        chk("l64_first", b_out_first, 1'b1);
        chk("l64_last",  b_out_last,  1'b1);
        chk("l64_data",  b_out_data,  b_exp);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("l64_valid_falls", b_out_valid, 1'b0);
        a_out_ready = 1'b1;
        for (int b = 0; b < 64; b++) begin
            chk("l1_valid", a_out_valid, 1'b1);
            chk("l1_data",  a_out_data,  10'(zz[b]));
            if (b == 2) chk("l1_beat2_is_8", a_out_data, 10'd8);
            chk("l1_first", a_out_first, b == 0);
            chk("l1_last",  a_out_last,  b == 63);
            tick();
        end
        a_out_ready = 1'b0;
        chk("l1_valid_falls", a_out_valid, 1'b0);

        // Single block, table-driven beat check
        out_ready = 1'b1;
        send_block(0);
        drain_table("single");

        // Backpressure: two blocks fill both banks, then drain without gaps
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 24; i++) begin
            in_row = mk_row((acc < 8) ? 100 : 200, acc % 8);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, 16);
        chk("bp_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            blk = (i < 8) ? 100 : 200;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data",  out_data,  exp_beat(blk, i % 8));
            chk("bp_first", out_first, (i % 8) == 0);
            chk("bp_last",  out_last,  (i % 8) == 7);
            if (i == 7) chk("bp_in_ready_before_free", in_ready, 1'b0);
            if (i == 8) chk("bp_in_ready_after_free", in_ready, 1'b1);
            tick();
        end
        chk("bp_valid_falls", out_valid, 1'b0);

        // Random out_ready with scoreboard and stall-stability checks
        rows_sent = 0;
        obeat = 0;
        stalled = 1'b0;
        prev_data = '0; prev_first = 1'b0; prev_last = 1'b0;
        cyc = 0;
        while ((rows_sent < 24 || exp_q.size() > 0) && cyc < 600) begin
            in_valid  = (rows_sent < 24);
            in_row    = mk_row(300 + 100 * (rows_sent / 8), rows_sent % 8);
            out_ready = 1'($urandom_range(0, 1));
            if (stalled) begin
                chk("rnd_stall_valid", out_valid, 1'b1);
                chk("rnd_stall_data",  out_data,  prev_data);
                chk("rnd_stall_first", out_first, prev_first);
                chk("rnd_stall_last",  out_last,  prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    chk("rnd_data", out_data, exp_q.pop_front());
                end
                chk("rnd_first", out_first, obeat == 0);
                chk("rnd_last",  out_last,  obeat == 7);
                obeat = (obeat + 1) % 8;
            end
            stalled    = out_valid && !out_ready;
            prev_data  = out_data;
            prev_first = out_first;
            prev_last  = out_last;
            if (in_valid && in_ready) begin
                if (rows_sent % 8 == 7) begin
                    for (int b = 0; b < 8; b++) exp_q.push_back(exp_beat(300 + 100 * (rows_sent / 8), b));
                end
                rows_sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rnd_rows_sent", rows_sent, 24);
        chk("rnd_queue_empty", exp_q.size(), 0);

        // sync_clear with one full block pending and a partial block of 3 rows
        for (int r = 0; r < 11; r++) begin
            in_valid = 1'b1;
            in_row   = mk_row((r < 8) ? 600 : 700, r % 8);
            chk("sc_fill_in_ready", in_ready, 1'b1);
            tick();
        end
        chk("sc_pending_valid", out_valid, 1'b1);
        in_row     = mk_row(700, 3);
        out_ready  = 1'b1;
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        chk("sc_out_valid", out_valid, 1'b0);
        chk("sc_in_ready",  in_ready,  1'b1);
        chk("sc_out_data",  out_data,  80'd0);
        chk("sc_out_first", out_first, 1'b0);
        chk("sc_out_last",  out_last,  1'b0);
        tick();
        chk("sc_still_empty", out_valid, 1'b0);
        out_ready = 1'b1;
        send_block(0);
        drain_table("after_clear");

        // Asynchronous reset mid-traffic
        out_ready = 1'b0;
        for (int r = 0; r < 13; r++) begin
            in_valid = 1'b1;
            in_row   = mk_row((r < 8) ? 800 : 900, r % 8);
            tick();
        end
        chk("ar_pending_valid", out_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_in_ready",  in_ready,  1'b1);
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_out_data",  out_data,  80'd0);
        chk("ar_out_first", out_first, 1'b0);
        chk("ar_out_last",  out_last,  1'b0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_post_release_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        send_block(0);
        drain_table("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_pingpong_buffer.md
# zigzag_pingpong_buffer

Double-buffered 8x8 coefficient block buffer that sits between the quantizer and the entropy-coding stage. It accepts one 8-coefficient row per handshake and emits the block in JPEG zigzag order, OUT_LANES coefficients per beat. It uses valid/ready flow control on both sides. With two banks, block n+1 can be written while block n drains.

## Interface
- DATA_WIDTH, 10, bits per coefficient; copied verbatim, no sign or arithmetic interpretation.
- OUT_LANES, 8, coefficients per output beat; legal values 1, 2, 4, 8, 16, 32, 64. BEATS = 64/OUT_LANES.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sync_clear  in  1  synchronous abort; discards all stored and partial blocks.
- in_valid  in  1  in_row holds a valid row.
- in_ready  out  1  buffer can accept a row this cycle.
- in_row  in  8*DATA_WIDTH  one row; column c at [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_LANES*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH] = zigzag index beat*OUT_LANES+k.
- out_first  out  1  current beat is beat 0 of a block.
- out_last  out  1  current beat is beat BEATS-1 of a block.

## Operation
- Storage is two banks of 64 x DATA_WIDTH. Per-bank full flag. Pointers: wr_bank, wr_row (0..7), rd_bank, rd_beat (0..BEATS-1).
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready, store in_row into position wr_row*8+c of bank wr_bank, then increment wr_row.
  - On acceptance of row 7: set full[wr_bank], toggle wr_bank, reset wr_row to 0.
- Read side:
  - out_valid = full[rd_bank].
  - Lane k of the beat takes the bank element at row-major position ZZ[rd_beat*OUT_LANES+k], where ZZ = 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
  - On out_valid && out_ready, increment rd_beat.
  - On the final beat: clear full[rd_bank], toggle rd_bank, reset rd_beat to 0.
- out_first = out_valid && rd_beat==0. out_last = out_valid && rd_beat==BEATS-1.
- When out_valid=0, out_data, out_first and out_last are driven 0.
- out_data, out_first, out_last and in_ready are functions of registered state only. There is no combinational path from in_valid/out_ready to any output.
- Holding rule: while out_valid && !out_ready, out_data and the markers stay stable.
- Bank full and empty: with both banks full, in_ready=0 and input stalls. With both banks empty, out_valid=0.
- Simultaneous events:
  - A write into one bank and a read from the other in the same cycle are independent. Both proceed.
  - A final-beat handshake frees its bank; in_ready for that bank rises the next cycle.
  - Setting and clearing of the same bank's flag cannot coincide: the writer only targets non-full banks, the reader only drains full ones.
- sync_clear has priority over all handshakes in its cycle; handshakes in that cycle are dropped. Next cycle all flags, pointers and outputs equal their reset values.
- Storage contents are not reset; they are unobservable until rewritten.

## Timing
- Reset (async assert) values: in_ready=1, out_valid=0, out_data=0, out_first=0, out_last=0. All pointers and flags are 0.
- Latency: out_valid rises in the cycle after the row-7 handshake. Beat 0 is visible in that same cycle.
- Throughput:
  - Input is 1 row per cycle sustained while a bank is free.
  - Output is 1 beat per cycle with no bubble between blocks when the other bank is already full.
  - With OUT_LANES=8 and both sides continuously active, the buffer streams one block per 8 cycles.
- Reset asserted mid-block aborts the block immediately. The first post-reset row is row 0 of bank 0.

## Test plan
- Reset: assert reset_n=0 mid-traffic -> in_ready=1, out_valid=0, out_data=0 immediately. After release, the first block goes to bank 0.
- Single block, OUT_LANES=8, row r column c = r*8+c, out_ready=1:
  - out_valid rises the cycle after the 8th accept.
  - Beat 0 = 0,1,8,16,9,2,3,10 with out_first=1.
  - Beat 7 = 53,60,61,54,47,55,62,63 with out_last=1.
  - out_valid falls after beat 7.
- Backpressure, out_ready=0, in_valid held high:
  - Exactly 16 rows are accepted, then in_ready=0.
  - Release out_ready -> 16 beats with no gap, block A then block B.
  - in_ready rises the cycle after A's last beat.
- Random out_ready toggling -> out_data/out_first/out_last are stable on every stalled cycle; the sequence matches the scoreboard.
- sync_clear after 3 rows of a block, plus one full block pending -> next cycle out_valid=0, in_ready=1. The following 8 rows form a correct block.
- Parameter sweep: OUT_LANES=1 gives 64 beats, beat 2 = 8. OUT_LANES=64 gives a single beat with out_first=out_last=1, lanes equal to the ZZ list. DATA_WIDTH=12 with negative values passes bits unchanged.
